// File: rtl/spi_cmd_controller_if.sv
// Bundle of signals between the command controller, the SPI peripheral,
// the image buffer and the inference core.
interface spi_cmd_controller_if #(
  parameter int ADDR_W = 7
);
  logic              byte_valid;
  logic [7:0]        rx_byte;
  logic              spi_error;
  logic              byte_ready;
  logic              rx_enable;
  logic              tx_enable;
  logic [7:0]        tx_byte;
  logic              img_wr_en;
  logic [ADDR_W-1:0] img_wr_addr;
  logic [7:0]        img_wr_data;
  logic              infer_start;
  logic              infer_busy;
  logic              infer_done;
  logic [3:0]        infer_class;
  logic              cmd_error;
  logic [1:0]        debug_state;

  // The controller drives the bus as master; peripheral, buffer and core sit on the slave side.
  modport master (
    input  byte_valid, rx_byte, spi_error, infer_busy, infer_done, infer_class,
    output byte_ready, rx_enable, tx_enable, tx_byte, img_wr_en, img_wr_addr,
           img_wr_data, infer_start, cmd_error, debug_state
  );

  modport slave (
    output byte_valid, rx_byte, spi_error, infer_busy, infer_done, infer_class,
    input  byte_ready, rx_enable, tx_enable, tx_byte, img_wr_en, img_wr_addr,
           img_wr_data, infer_start, cmd_error, debug_state
  );
endinterface

// File: rtl/spi_cmd_controller.sv
// Host command sequencer above spi_peripheral: image upload, inference start,
// and status/result bytes returned on the following SPI transfer.
module spi_cmd_controller #(
  parameter int IMG_BYTES = 113,
  parameter int ADDR_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_cmd_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IMG_LOAD = 2'd1,
    S_INFER    = 2'd2
  } state_t;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_IMG_WR = 8'hA1;
  localparam logic [7:0] CMD_START  = 8'hA2;
  localparam logic [7:0] CMD_STATUS = 8'hA3;
  localparam logic [7:0] CMD_RESULT = 8'hA4;
  localparam logic [7:0] CMD_CLEAR  = 8'hA5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  state_t            state_q, state_d;
  logic              byte_valid_q;
  logic              en_q;
  logic [ADDR_W-1:0] img_count_q, img_count_d;
  logic              img_loaded_q, img_loaded_d;
  logic              result_valid_q, result_valid_d;
  logic [3:0]        result_class_q, result_class_d;
  logic              cmd_error_q, cmd_error_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              img_wr_en_q, img_wr_en_d;
  logic [ADDR_W-1:0] img_wr_addr_q, img_wr_addr_d;
  logic [7:0]        img_wr_data_q, img_wr_data_d;
  logic              infer_start_q, infer_start_d;

  logic       byte_strobe;
  logic [7:0] status_byte;
  logic [7:0] result_byte;

  // byte_valid stays high until CS deasserts, so only its rising edge counts as a new byte.
  assign byte_strobe = bus.byte_valid & ~byte_valid_q;
  assign status_byte = {bus.infer_busy, result_valid_q, img_loaded_q, cmd_error_q, 4'b0000};
  assign result_byte = result_valid_q ? {4'h0, result_class_q} : 8'hFF;

  always_comb begin
    state_d        = state_q;
    img_count_d    = img_count_q;
    img_loaded_d   = img_loaded_q;
    result_valid_d = result_valid_q;
    result_class_d = result_class_q;
    cmd_error_d    = cmd_error_q;
    tx_byte_d      = tx_byte_q;
    img_wr_en_d    = 1'b0;
    img_wr_addr_d  = img_wr_addr_q;
    img_wr_data_d  = img_wr_data_q;
    infer_start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_strobe) begin
          case (bus.rx_byte)
            CMD_NOP: ;
            CMD_IMG_WR: begin
              img_count_d  = '0;
              img_loaded_d = 1'b0;
              state_d      = S_IMG_LOAD;
            end
            CMD_START: begin
              if (img_loaded_q && !bus.infer_busy) begin
                infer_start_d  = 1'b1;
                result_valid_d = 1'b0;
                state_d        = S_INFER;
              end else begin
                cmd_error_d = 1'b1;
              end
            end
            CMD_STATUS: tx_byte_d = status_byte;
            CMD_RESULT: tx_byte_d = result_byte;
            CMD_CLEAR: begin
              cmd_error_d    = 1'b0;
              result_valid_d = 1'b0;
              img_loaded_d   = 1'b0;
              tx_byte_d      = 8'h00;
            end
            default: cmd_error_d = 1'b1;
          endcase
        end
      end

      S_IMG_LOAD: begin
        // A transfer timeout discards the partial frame; img_loaded was already cleared on entry.
        if (bus.spi_error) begin
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end else if (byte_strobe) begin
          img_wr_en_d   = 1'b1;
          img_wr_addr_d = img_count_q;
          img_wr_data_d = bus.rx_byte;
          img_count_d   = img_count_q + ADDR_W'(1);
          if (img_count_q == LAST_ADDR) begin
            img_loaded_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end

      S_INFER: begin
        if (bus.infer_done) begin
          result_class_d = bus.infer_class;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
        // STATUS here reports the pre-edge flags even if infer_done lands in the same cycle.
        if (byte_strobe) begin
          if (bus.rx_byte == CMD_STATUS) begin
            tx_byte_d = status_byte;
          end else if (bus.rx_byte != CMD_NOP) begin
            cmd_error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      byte_valid_q   <= 1'b0;
      en_q           <= 1'b0;
      img_count_q    <= '0;
      img_loaded_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= 4'h0;
      cmd_error_q    <= 1'b0;
      tx_byte_q      <= 8'h00;
      img_wr_en_q    <= 1'b0;
      img_wr_addr_q  <= '0;
      img_wr_data_q  <= 8'h00;
      infer_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_valid_q   <= bus.byte_valid;
      en_q           <= 1'b1;
      img_count_q    <= img_count_d;
      img_loaded_q   <= img_loaded_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      cmd_error_q    <= cmd_error_d;
      tx_byte_q      <= tx_byte_d;
      img_wr_en_q    <= img_wr_en_d;
      img_wr_addr_q  <= img_wr_addr_d;
      img_wr_data_q  <= img_wr_data_d;
      infer_start_q  <= infer_start_d;
    end
  end

  assign bus.byte_ready  = en_q;
  assign bus.rx_enable   = en_q;
  assign bus.tx_enable   = en_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.img_wr_en   = img_wr_en_q;
  assign bus.img_wr_addr = img_wr_addr_q;
  assign bus.img_wr_data = img_wr_data_q;
  assign bus.infer_start = infer_start_q;
  assign bus.cmd_error   = cmd_error_q;
  assign bus.debug_state = state_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed self-checking bench for spi_cmd_controller; inputs change and
// outputs are sampled on the falling clock edge.
module tb_spi_cmd_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  spi_cmd_controller_if #(.ADDR_W(7)) bus ();

  spi_cmd_controller #(.IMG_BYTES(113), .ADDR_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One SPI byte: valid held for three cycles, then released for one.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte    = b;
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] exp);
    checks++;
    if (bus.tx_byte !== exp) begin
      failures++;
      $display("FAIL %s: tx_byte=%h expected=%h", name, bus.tx_byte, exp);
    end
  endtask

  task automatic test_reset;
    logic [30:0] outs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outs = {bus.byte_ready, bus.rx_enable, bus.tx_enable, bus.tx_byte, bus.img_wr_en,
            bus.img_wr_addr, bus.img_wr_data, bus.infer_start, bus.cmd_error, bus.debug_state};
    checks++;
    if (outs !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs: got=%h expected=0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.byte_ready, bus.rx_enable, bus.tx_enable, bus.debug_state} !== 5'b11100) begin
      failures++;
      $display("FAIL enables_after_release: got=%b expected=11100",
               {bus.byte_ready, bus.rx_enable, bus.tx_enable, bus.debug_state});
    end
  endtask

  task automatic test_img_load;
    send_byte(8'hA1);
    checks++;
    if (bus.debug_state !== 2'd1) begin
      failures++;
      $display("FAIL load_state: debug_state=%0d expected=1", bus.debug_state);
    end
    for (int i = 0; i < 113; i++) begin
      @(negedge clk);
      bus.rx_byte    = 8'(i);
      bus.byte_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.img_wr_en, bus.img_wr_addr, bus.img_wr_data} !== {1'b1, 7'(i), 8'(i)}) begin
        failures++;
        $display("FAIL img_write[%0d]: en/addr/data=%b/%0d/%h expected 1/%0d/%h",
                 i, bus.img_wr_en, bus.img_wr_addr, bus.img_wr_data, i, i[7:0]);
      end
      @(negedge clk);
      checks++;
      if (bus.img_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL img_wr_pulse_width[%0d]: img_wr_en=%b expected=0", i, bus.img_wr_en);
      end
      bus.byte_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus.debug_state !== 2'd0) begin
      failures++;
      $display("FAIL load_return_idle: debug_state=%0d expected=0", bus.debug_state);
    end
    send_byte(8'hA3);
    expect_tx("status_after_load", 8'h20);
  endtask

  task automatic test_infer;
    int starts;
    @(negedge clk);
    bus.rx_byte    = 8'hA2;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.infer_start, bus.debug_state} !== 3'b110) begin
      failures++;
      $display("FAIL infer_start_pulse: start/state=%b/%0d expected 1/2",
               bus.infer_start, bus.debug_state);
    end
    bus.infer_busy = 1'b1;
    starts = 0;
    @(negedge clk);
    if (bus.infer_start) starts++;
    bus.byte_valid = 1'b0;
    send_byte(8'hA3);
    expect_tx("status_during_infer", 8'hA0);
    repeat (14) begin
      @(negedge clk);
      if (bus.infer_start) starts++;
    end
    checks++;
    if (starts !== 0) begin
      failures++;
      $display("FAIL infer_start_single: extra pulses=%0d expected=0", starts);
    end
    bus.infer_done  = 1'b1;
    bus.infer_class = 4'd7;
    @(negedge clk);
    bus.infer_done = 1'b0;
    bus.infer_busy = 1'b0;
    checks++;
    if (bus.debug_state !== 2'd0) begin
      failures++;
      $display("FAIL infer_done_idle: debug_state=%0d expected=0", bus.debug_state);
    end
    send_byte(8'hA4);
    expect_tx("result_class7", 8'h07);
    send_byte(8'hA3);
    expect_tx("status_after_result", 8'h60);
  endtask

  task automatic test_start_no_image;
    send_byte(8'hA5);
    @(negedge clk);
    bus.rx_byte    = 8'hA2;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.infer_start, bus.cmd_error, bus.debug_state} !== 4'b0100) begin
      failures++;
      $display("FAIL start_rejected: start/err/state=%b/%b/%0d expected 0/1/0",
               bus.infer_start, bus.cmd_error, bus.debug_state);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    send_byte(8'hA3);
    expect_tx("status_error", 8'h10);
    send_byte(8'hA5);
    expect_tx("clear_tx", 8'h00);
    checks++;
    if (bus.cmd_error !== 1'b0) begin
      failures++;
      $display("FAIL clear_error: cmd_error=%b expected=0", bus.cmd_error);
    end
  endtask

  task automatic test_spi_abort;
    send_byte(8'hA1);
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i));
    @(negedge clk);
    bus.spi_error = 1'b1;
    @(negedge clk);
    bus.spi_error = 1'b0;
    checks++;
    if ({bus.debug_state, bus.cmd_error} !== 3'b001) begin
      failures++;
      $display("FAIL abort_state: state/err=%0d/%b expected 0/1", bus.debug_state, bus.cmd_error);
    end
    send_byte(8'hA3);
    expect_tx("status_after_abort", 8'h10);
    @(negedge clk);
    bus.rx_byte    = 8'hA2;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.infer_start, bus.debug_state} !== 3'b000) begin
      failures++;
      $display("FAIL start_after_abort: start/state=%b/%0d expected 0/0",
               bus.infer_start, bus.debug_state);
    end
    bus.byte_valid = 1'b0;
    @(negedge clk);
    send_byte(8'hA5);
  endtask

  task automatic test_hold_valid;
    int writes;
    @(negedge clk);
    bus.rx_byte    = 8'h5B;
    bus.byte_valid = 1'b1;
    repeat (50) @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_error !== 1'b1) begin
      failures++;
      $display("FAIL illegal_cmd_error: cmd_error=%b expected=1", bus.cmd_error);
    end
    send_byte(8'hA4);
    expect_tx("result_none", 8'hFF);
    // Long hold in load state must write exactly once.
    send_byte(8'hA1);
    writes = 0;
    @(negedge clk);
    bus.rx_byte    = 8'h5B;
    bus.byte_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.img_wr_en) writes++;
    end
    bus.byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (writes !== 1) begin
      failures++;
      $display("FAIL hold_single_write: writes=%0d expected=1", writes);
    end
    @(negedge clk);
    bus.rx_byte    = 8'h3C;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.img_wr_en, bus.img_wr_addr, bus.img_wr_data} !== {1'b1, 7'd1, 8'h3C}) begin
      failures++;
      $display("FAIL hold_next_addr: en/addr/data=%b/%0d/%h expected 1/1/3c",
               bus.img_wr_en, bus.img_wr_addr, bus.img_wr_data);
    end
    bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.spi_error = 1'b1;
    @(negedge clk);
    bus.spi_error = 1'b0;
    send_byte(8'hA5);
  endtask

  task automatic test_reset_mid_load;
    send_byte(8'hA1);
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.debug_state, bus.img_wr_addr} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset_mid_load: state/addr=%0d/%0d expected 0/0",
               bus.debug_state, bus.img_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hA3);
    expect_tx("status_after_reset", 8'h00);
  endtask

  task automatic test_simultaneous;
    send_byte(8'hA1);
    for (int i = 0; i < 113; i++) send_byte(8'hFF - 8'(i));
    send_byte(8'hA2);
    bus.infer_busy = 1'b1;
    repeat (3) @(negedge clk);
    bus.infer_done  = 1'b1;
    bus.infer_class = 4'd3;
    bus.rx_byte     = 8'hA3;
    bus.byte_valid  = 1'b1;
    @(negedge clk);
    bus.infer_done = 1'b0;
    bus.infer_busy = 1'b0;
    checks++;
    if ({bus.tx_byte, bus.debug_state} !== {8'hA0, 2'd0}) begin
      failures++;
      $display("FAIL done_and_status: tx/state=%h/%0d expected a0/0", bus.tx_byte, bus.debug_state);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    send_byte(8'hA4);
    expect_tx("result_class3", 8'h03);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.byte_valid  = 1'b0;
    bus.rx_byte     = 8'h00;
    bus.spi_error   = 1'b0;
    bus.infer_busy  = 1'b0;
    bus.infer_done  = 1'b0;
    bus.infer_class = 4'h0;
    test_reset;
    test_img_load;
    test_infer;
    test_start_no_image;
    test_spi_abort;
    test_hold_valid;
    test_reset_mid_load;
    test_simultaneous;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_controller.md
# spi_cmd_controller

- Command sequencer sitting directly above `spi_peripheral` in the OCR FPGA top level.
- Turns the peripheral's received bytes into host commands:
  - streams image bytes into the image buffer;
  - starts the BNN inference core;
  - serves status and result bytes back to the host on the next SPI transfer.
- Owns every control input of `spi_peripheral` and the handshake with the inference core.

## Interface

- `IMG_BYTES`, 113, image bytes per frame (900-bit 30x30 image, zero-padded).
- `ADDR_W`, 7, image buffer address width; must satisfy 2^ADDR_W >= IMG_BYTES.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  from peripheral; high from byte completion until CS deasserts.
- `rx_byte`  in  8  from peripheral; received byte, stable while `byte_valid` is high.
- `spi_error`  in  1  from peripheral; transfer timeout.
- `byte_ready`  out  1  to peripheral; tx byte available.
- `rx_enable`  out  1  to peripheral.
- `tx_enable`  out  1  to peripheral.
- `tx_byte`  out  8  to peripheral; byte returned on the next transfer.
- `img_wr_en`  out  1  image buffer write strobe.
- `img_wr_addr`  out  ADDR_W  image buffer write address.
- `img_wr_data`  out  8  image buffer write data.
- `infer_start`  out  1  one-cycle start pulse to the inference core.
- `infer_busy`  in  1  inference core busy.
- `infer_done`  in  1  one-cycle completion pulse from the inference core.
- `infer_class`  in  4  class index; valid with `infer_done`.
- `cmd_error`  out  1  sticky protocol error.
- `debug_state`  out  2  current FSM state encoding.

## Operation

**Byte strobe**
- `byte_strobe` = `byte_valid & ~byte_valid_q`, where `byte_valid_q` is registered.
- Each SPI byte is therefore processed exactly once.

**States:** `S_IDLE`=0, `S_IMG_LOAD`=1, `S_INFER`=2.

**Command decode in S_IDLE, on `byte_strobe`**
- 0x00 NOP: no action.
- 0xA1 IMG_WRITE: clear `img_count` and `img_loaded`; go to `S_IMG_LOAD`.
- 0xA2 START:
  - If `img_loaded` and not `infer_busy`: pulse `infer_start`, clear `result_valid`, go to `S_INFER`.
  - Otherwise: set `cmd_error` and stay in `S_IDLE`.
- 0xA3 STATUS: `tx_byte` <= {`infer_busy`, `result_valid`, `img_loaded`, `cmd_error`, 4'b0000}.
- 0xA4 RESULT: `tx_byte` <= `result_valid` ? {4'h0, `result_class`} : 8'hFF.
- 0xA5 CLEAR: clear `cmd_error`, `result_valid` and `img_loaded`; `tx_byte` <= 8'h00.
- Any other value: set `cmd_error`.

**S_IMG_LOAD**
- On each `byte_strobe`: `img_wr_en`=1 for one cycle, `img_wr_addr`=`img_count`, `img_wr_data`=`rx_byte`, then `img_count`++.
- After the write at `img_count`==IMG_BYTES-1: set `img_loaded` and return to `S_IDLE`.
- Command bytes are not decoded in this state; every byte is data.
- `spi_error`=1 in this state: abort, set `cmd_error`, leave `img_loaded`=0, return to `S_IDLE`.

**S_INFER**
- On `infer_done`: latch `infer_class` into `result_class`, set `result_valid`, go to `S_IDLE`.
- Incoming bytes in this state:
  - 0xA3 is served as in `S_IDLE`;
  - 0x00 is ignored;
  - anything else sets `cmd_error`.

**Other rules**
- `spi_error` in `S_IDLE` or `S_INFER` is ignored.
- `cmd_error` stays set until CLEAR or reset.

## Timing

**Reset values** (all outputs and internal flags)
- All outputs 0, including `tx_byte`=8'h00 and `debug_state`=0.
- `img_count`, `result_class`, `img_loaded` and `result_valid` are 0.

**Peripheral enables**
- `byte_ready`, `rx_enable` and `tx_enable` are registered.
- They go to 1 on the first clock edge after `rst_n` deasserts and then stay at 1.

**Latencies**
- `byte_valid` rises in cycle N: `byte_strobe` is high in cycle N, and the decode or write takes effect at the N→N+1 edge.
- So `img_wr_en`, `infer_start`, `tx_byte` and state changes are visible in cycle N+1.
- `img_wr_en` and `infer_start` are exactly one cycle wide.
- `infer_done` in cycle M: `result_valid` and `result_class` are visible in cycle M+1.

**Simultaneous events**
- `infer_done` and `byte_strobe` in the same cycle in `S_INFER`: both are processed. A STATUS byte captures the flag values from before the edge.

**Reset mid-operation**
- Asynchronous reset mid-load or mid-inference returns to `S_IDLE` immediately.
- All partial progress is discarded.

**Byte sequencing**
- `tx_byte` is only updated on a strobe. The peripheral reloads it in its own idle state, so a response is returned on the transfer after the command.

## Test plan

1. Reset, then release:
   - all outputs are 0 during reset;
   - `byte_ready`, `rx_enable` and `tx_enable` are 1 one cycle after release;
   - `debug_state`=0.
2. Send 0xA1 followed by 113 bytes 0x00..0x70:
   - 113 single-cycle `img_wr_en` pulses with `img_wr_addr`=0..112 and `img_wr_data` equal to the addr;
   - then STATUS gives `tx_byte`=8'h20.
3. After a full load, send 0xA2; 20 cycles later pulse `infer_done` with `infer_class`=7:
   - `infer_start` pulses once, one cycle after the strobe;
   - RESULT then gives `tx_byte`=8'h07;
   - STATUS gives 8'h60.
4. Send 0xA2 with no image loaded:
   - no `infer_start`;
   - `cmd_error`=1;
   - STATUS gives 8'h10;
   - CLEAR returns `cmd_error`=0 and `tx_byte`=8'h00.
5. Send 0xA1 and 10 data bytes, then assert `spi_error`:
   - the FSM returns to `S_IDLE`;
   - `cmd_error`=1 and `img_loaded`=0;
   - a following 0xA2 is rejected.
6. Hold `byte_valid` high for 50 cycles on byte 0x5B, then send 0xA4 before any result exists:
   - only one write or decode per byte;
   - 0x5B sets `cmd_error`;
   - RESULT gives `tx_byte`=8'hFF.
